// File: rtl/ltc2387_tx_emu.sv
// ltc2387_tx_emu: LTC2387 ADC-side serial transmitter emulator (1/2 lane, 16/18 bit, echoed DCO).
// Optional LTC2387_TX_PATTERN_TOGGLE_EN alternates the test pattern with its complement.
module ltc2387_tx_emu #(
    parameter int unsigned CONV_CYCLES = 22,
    parameter logic        IDLE_DATA   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cnv,
    input  logic [17:0] sample_in,
    input  logic        bits_18,
    input  logic        two_lane,
    input  logic        test_pattern,
    output logic        da,
    output logic        db,
    output logic        dco,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, CONV, SHIFT} state_t;
    state_t      state_q, state_d;
    logic        cnv_q;
    logic [7:0]  cyc_q, cyc_d;
    logic [4:0]  bit_q, bit_d;
    logic [17:0] sh_q, sh_d;
    logic        two_q, two_d;
    logic        dco_q, dco_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic        edge_det;
    logic [17:0] mask, tp, pat, word;
`ifdef LTC2387_TX_PATTERN_TOGGLE_EN
    logic        tog_q, tog_d;
`endif
    assign edge_det = cnv && !cnv_q;
    assign mask     = bits_18 ? 18'h3FFFF : 18'h0FFFF;
    assign tp       = bits_18 ? (two_lane ? 18'h330FC : 18'h281FC)
                              : (two_lane ? 18'h0CC3F : 18'h0A07F);
`ifdef LTC2387_TX_PATTERN_TOGGLE_EN
    assign pat      = tog_q ? (~tp & mask) : tp;
`else
    assign pat      = tp;
`endif
    assign word     = test_pattern ? pat : (sample_in & mask);
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        two_d   = two_q;
        dco_d   = dco_q;
        done_d  = 1'b0;
        ovr_d   = edge_det && (state_q != IDLE);
`ifdef LTC2387_TX_PATTERN_TOGGLE_EN
        tog_d   = tog_q;
`endif
        case (state_q)
            IDLE: if (edge_det) begin
                state_d = CONV;
                cyc_d   = CONV_CYCLES[7:0];
                // MSB-align the word so lane A always shifts out of bit 17
                sh_d    = bits_18 ? word : {word[15:0], 2'b00};
                two_d   = two_lane;
                bit_d   = (bits_18 ? 5'd18 : 5'd16) >> two_lane;
`ifdef LTC2387_TX_PATTERN_TOGGLE_EN
                tog_d   = tog_q ^ test_pattern;
`endif
            end
            CONV: begin
                cyc_d = cyc_q - 8'd1;
                if (cyc_q == 8'd1) begin
                    state_d = SHIFT;
                    dco_d   = 1'b1;
                end
            end
            SHIFT: begin
                sh_d  = two_q ? (sh_q << 2) : (sh_q << 1);
                bit_d = bit_q - 5'd1;
                dco_d = ~dco_q;
                if (bit_q == 5'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    dco_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnv_q   <= 1'b0;
            cyc_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            two_q   <= 1'b0;
            dco_q   <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef LTC2387_TX_PATTERN_TOGGLE_EN
            tog_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnv_q   <= cnv;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            two_q   <= two_d;
            dco_q   <= dco_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
`ifdef LTC2387_TX_PATTERN_TOGGLE_EN
            tog_q   <= tog_d;
`endif
        end
    end
    assign da      = (state_q == SHIFT) ? sh_q[17] : IDLE_DATA;
    assign db      = (state_q == SHIFT && two_q) ? sh_q[16] : IDLE_DATA;
    assign dco     = dco_q;
    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign overrun = ovr_q;
endmodule

// File: tb/tb_ltc2387_tx_emu.sv
// tb_ltc2387_tx_emu: scoreboard bench; a receiver-model monitor deserialises each frame and checks it.
module tb_ltc2387_tx_emu;
    localparam int CONV = 22;
    logic clk = 1'b0;
    logic rst_n, cnv, bits_18, two_lane, test_pattern;
    logic [17:0] sample_in;
    logic da, db, dco, busy, done, overrun;
    int total = 0;
    int bad = 0;
    int ov_cnt = 0;
    logic tog = 1'b0;
    typedef struct {logic [17:0] w; int n; logic two; logic ab;} exp_t;
    exp_t sb[$];

    ltc2387_tx_emu #(.CONV_CYCLES(CONV), .IDLE_DATA(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .cnv(cnv), .sample_in(sample_in), .bits_18(bits_18),
        .two_lane(two_lane), .test_pattern(test_pattern), .da(da), .db(db), .dco(dco),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (overrun) ov_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue a conversion at the current negedge and push what the receiver should read.
    task automatic send(input logic [17:0] s, input logic b18, input logic tw, input logic tpe, input logic ab);
        exp_t e;
        logic [17:0] m, t;
        m = b18 ? 18'h3FFFF : 18'h0FFFF;
        t = b18 ? (tw ? 18'h330FC : 18'h281FC) : (tw ? 18'h0CC3F : 18'h0A07F);
`ifdef LTC2387_TX_PATTERN_TOGGLE_EN
        if (tog) t = ~t & m;
        if (tpe) tog = ~tog;
`endif
        e.w = tpe ? t : (s & m);
        e.n = b18 ? (tw ? 9 : 18) : (tw ? 8 : 16);
        e.two = tw;
        e.ab = ab;
        sb.push_back(e);
        sample_in = s; bits_18 = b18; two_lane = tw; test_pattern = tpe; cnv = 1'b1;
        @(negedge clk);
        cnv = 1'b0;
        sample_in = ~s; bits_18 = ~b18; two_lane = ~tw; test_pattern = ~tpe;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || done) && k < 2000) begin @(negedge clk); k++; end
        if (k >= 2000) chk("idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_dco();
        int k = 0;
        while (!dco && k < 500) begin @(negedge clk); k++; end
        if (k >= 500) chk("dco_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 500) begin @(negedge clk); k++; end
        if (k >= 500) chk("done_timeout", 1, 0);
    endtask

    initial begin : mon
        exp_t e;
        int lat, k;
        logic [17:0] w;
        logic db_any, dco_bad, busy_bad;
        forever begin
            @(negedge clk);
            if (busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    k = 0;
                    while (busy && k < 2000) begin @(negedge clk); k++; end
                end else begin
                    e = sb.pop_front();
                    if (e.ab) begin
                        k = 0;
                        while (busy && k < 2000) begin @(negedge clk); k++; end
                    end else begin
                        lat = 0;
                        busy_bad = 1'b0;
                        while (!dco && lat < 300) begin
                            busy_bad |= !busy || da || db;
                            @(negedge clk);
                            lat++;
                        end
                        chk("latency", lat, CONV);
                        w = '0; db_any = 1'b0; dco_bad = 1'b0;
                        for (int i = 0; i < e.n; i++) begin
                            if (e.two) w = {w[15:0], da, db};
                            else begin w = {w[16:0], da}; db_any |= db; end
                            dco_bad |= (dco != ((i % 2) == 0));
                            busy_bad |= !busy;
                            @(negedge clk);
                        end
                        chk("rx_word", w, e.w);
                        chk("db_idle_1lane", db_any, 0);
                        chk("dco_pattern", dco_bad, 0);
                        chk("busy_and_idle_lanes_in_frame", busy_bad, 0);
                        chk("done_after_last", {done, busy, dco}, 3'b100);
                    end
                end
            end
        end
    end

    initial begin
        int ov0;
        rst_n = 1'b0; cnv = 1'b0; sample_in = '0; bits_18 = 1'b0; two_lane = 1'b0; test_pattern = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {da, db, dco, busy, done, overrun}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(18'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle();
        send(18'h1ABCD, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle();
        ov0 = ov_cnt;
        send(18'h2F00F, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_dco();
        cnv = 1'b1;
        @(negedge clk);
        cnv = 1'b0;
        wait_idle();
        chk("overrun_one_pulse", ov_cnt - ov0, 1);
        send(18'h2A5A5, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_done();
        send(18'h15A3C, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("no_overrun_on_done_edge", ov_cnt - ov0, 1);
        send(18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_dco();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        tog = 1'b0;
        #1;
        chk("reset_midframe", {da, db, dco, busy, done, overrun}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("quiet_after_reset", {busy, da, dco, done}, 0);
        send(18'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        send(18'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        send(18'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_idle();
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ltc2387_tx_emu.md
Name: ltc2387_tx_emu

Overview:
- Serial-transmitter emulator for the ADC side of the LTC2387 LVDS interface, driven from the capture logic's internal high-speed clock.
- On each conversion request it emits a 16/18-bit sample on one or two lanes with an echoed DCO, bit-for-bit in the format the host receiver deserialises.
- Used for FPGA loopback and simulation of the capture path without a DC2290A fitted.
- One DDR bit interval is modelled as one clk cycle; DCO toggles once per bit.

Parameters:
- CONV_CYCLES, 22: clk cycles from the detected cnv edge to the first output bit (conversion latency); legal 1..255.
- IDLE_DATA, 0: level driven on da/db while not shifting.

Ports:
- clk  input  1  internal high-speed clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cnv  input  1  conversion request, level sampled; a rising edge starts a conversion.
- sample_in  input  18  sample to transmit; LSB-justified; bits [17:16] ignored in 16-bit mode.
- bits_18  input  1  1 = 18-bit word, 0 = 16-bit word.
- two_lane  input  1  1 = lanes A+B, 0 = lane A only.
- test_pattern  input  1  1 = transmit the fixed test pattern instead of sample_in.
- da  output  1  lane A serial data.
- db  output  1  lane B serial data.
- dco  output  1  data clock out; toggles once per bit.
- busy  output  1  high from the cycle after edge detect until the last bit has been sent.
- done  output  1  one-cycle pulse on the cycle after the last bit.
- overrun  output  1  one-cycle pulse when a cnv edge arrives while busy.

Behaviour:
- Reset (asynchronous, rst_n=0): da=db=IDLE_DATA, dco=0, busy=0, done=0, overrun=0, state=IDLE, cnv history register=0. Releasing reset mid-frame abandons the frame; no partial bits are sent afterwards.
- Edge detect: cnv is registered once. An edge is detected when cnv=1 and the history register is 0.
- The following are latched in the edge cycle: word = test_pattern ? TP : sample_in masked to 16/18 bits; mode bits; N = (bits_18 ? 18 : 16) >> two_lane.
- Test pattern TP:
  - 1 lane, 18-bit: 0x281FC (164348).
  - 1 lane, 16-bit: 0xA07F (41087).
  - 2 lane, 18-bit: 0x330FC (209148).
  - 2 lane, 16-bit: 0xCC3F (52287).
- State IDLE: da/db at IDLE_DATA, dco=0. On edge -> CONV, load the cycle counter with CONV_CYCLES.
- State CONV: counter decrements each cycle; busy=1. At 0 -> SHIFT, load the bit counter with N.
- State SHIFT: one bit per cycle, MSB first. dco=1 on the first bit and inverts on each subsequent bit.
  - 1 lane: da carries D[W-1] down to D0; db held at IDLE_DATA.
  - 2 lane: da carries the odd bits D[W-1], D[W-3]..D1; db carries the even bits D[W-2]..D0.
  - After bit N -> IDLE, done=1 for one cycle, busy=0 that same cycle, dco returns to 0.
- Latency: first bit is on da exactly CONV_CYCLES+1 cycles after the edge-detect cycle.
- cnv edge during CONV or SHIFT: frame continues unchanged, overrun pulses, and the request is dropped (not queued).
- cnv edge in the same cycle done pulses: state is already IDLE, so the edge is accepted and the new frame starts.
- Changes to sample_in, bits_18, two_lane or test_pattern mid-frame have no effect until the next edge.

Optional Feature:
- Macro LTC2387_TX_PATTERN_TOGGLE_EN.
- Defined: a 1-bit toggle register, reset 0, flips on every accepted conversion while test_pattern=1. When the toggle is 1, the bitwise complement of TP, masked to the word width, is sent. The alternating frames check every bit position of the receiver in both polarities.
- Undefined: TP is always sent unmodified and the register is absent.

Test Plan:
- 1 lane, 18-bit, test_pattern=1, single cnv pulse -> da = 1,0,1,0,0,0,0,0,0,1,1,1,1,1,1,1,0,0 starting 23 cycles after edge detect; dco 1,0,1,...; done pulses once; receiver reads 164348.
- 2 lane, 16-bit, sample_in=0x1ABCD -> 8 bits per lane; da = D15,D13..D1 and db = D14..D0 of 0xABCD; busy high for 22+8 cycles.
- cnv edge mid-SHIFT -> frame unaltered, overrun=1 for one cycle, no second frame.
- cnv edge in the done cycle -> new frame starts, first bit CONV_CYCLES+1 cycles later.
- rst_n low mid-frame -> all outputs at reset values immediately; after release, a new cnv edge is required before any bits are sent.
- LTC2387_TX_PATTERN_TOGGLE_EN, 1 lane, 16-bit, two conversions -> 0xA07F then 0x5F80.
